// File: rtl/sram_bus_arbiter.sv
// Arbiter sharing BaseRAM and ExtRAM between the fetch port and the load/store port.
// One access at a time: IDLE -> ACCESS (ACCESS_CYCLES cycles) -> DONE (ready pulse) -> IDLE.
module sram_bus_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 20
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              inst_req_i,
    input  logic [31:0]       inst_addr_i,
    output logic              inst_ready_o,
    output logic [31:0]       inst_rdata_o,
    input  logic              data_req_i,
    input  logic [3:0]        data_we_i,
    input  logic [31:0]       data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic              data_ready_o,
    output logic [31:0]       data_rdata_o,
    output logic              grant_inst_o,
    output logic              grant_data_o,
    output logic [ADDR_W-1:0] base_ram_addr_o,
    output logic [3:0]        base_ram_be_n_o,
    output logic              base_ram_ce_n_o,
    output logic              base_ram_oe_n_o,
    output logic              base_ram_we_n_o,
    output logic [31:0]       base_ram_data_o,
    output logic              base_ram_data_oe_o,
    input  logic [31:0]       base_ram_data_i,
    output logic [ADDR_W-1:0] ext_ram_addr_o,
    output logic [3:0]        ext_ram_be_n_o,
    output logic              ext_ram_ce_n_o,
    output logic              ext_ram_oe_n_o,
    output logic              ext_ram_we_n_o,
    output logic [31:0]       ext_ram_data_o,
    output logic              ext_ram_data_oe_o,
    input  logic [31:0]       ext_ram_data_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be_n;
        logic              ce_n;
        logic              oe_n;
        logic              we_n;
        logic              data_oe;
        logic [31:0]       data;
    } ram_bus_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES);
    localparam ram_bus_t   BUS_IDLE = '{addr: {ADDR_W{1'b0}}, be_n: 4'b1111, ce_n: 1'b1,
                                        oe_n: 1'b1, we_n: 1'b1, data_oe: 1'b0, data: 32'd0};

    function automatic logic addr_is_ext(input logic [31:0] a);
        return a[22];
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] a);
        return a[ADDR_W+1:2];
    endfunction

    // The write strobe is released on the last cycle so address and data are held past we_n rising.
    function automatic ram_bus_t ram_drive(input logic sel, input logic wr, input logic we_pulse,
                                           input logic [ADDR_W-1:0] addr, input logic [3:0] we,
                                           input logic [31:0] wdata, input logic [ADDR_W-1:0] prev_addr);
        ram_bus_t b;
        b      = BUS_IDLE;
        b.addr = prev_addr;
        if (sel) begin
            b.addr = addr;
            b.ce_n = 1'b0;
            if (wr) begin
                b.be_n    = ~we;
                b.we_n    = ~we_pulse;
                b.data_oe = 1'b1;
                b.data    = wdata;
            end else begin
                b.be_n = 4'b0000;
                b.oe_n = 1'b0;
            end
        end else begin
            b.addr = prev_addr;
        end
        return b;
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_inst_q, last_inst_d;
    logic              own_data_q, own_data_d;
    logic              tgt_ext_q, tgt_ext_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [3:0]        we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              pick_data_s;

    logic              inst_ready_q, data_ready_q, grant_inst_q, grant_data_q;
    logic [31:0]       inst_rdata_q, data_rdata_q;
    ram_bus_t          base_q, base_d, ext_q, ext_d;
    logic              acc_s, wr_s, we_pulse_s, cap_s;
    logic [31:0]       rd_word_s;

    logic              unused_s;
    assign unused_s = ^{inst_addr_i[31:23], inst_addr_i[1:0], data_addr_i[31:23], data_addr_i[1:0]};

    // Next-state logic: arbitration in IDLE, cycle counting in ACCESS.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_inst_d = last_inst_q;
        own_data_d  = own_data_q;
        tgt_ext_d   = tgt_ext_q;
        waddr_d     = waddr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        pick_data_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (inst_req_i || data_req_i) begin
                    pick_data_s = data_req_i && (!inst_req_i || last_inst_q);
                    state_d     = S_ACCESS;
                    cnt_d       = 4'd1;
                    own_data_d  = pick_data_s;
                    last_inst_d = !pick_data_s;
                    if (pick_data_s) begin
                        tgt_ext_d = addr_is_ext(data_addr_i);
                        waddr_d   = word_addr(data_addr_i);
                        we_d      = data_we_i;
                        wdata_d   = data_wdata_i;
                    end else begin
                        tgt_ext_d = addr_is_ext(inst_addr_i);
                        waddr_d   = word_addr(inst_addr_i);
                        we_d      = 4'b0000;
                        wdata_d   = wdata_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pad drive derived from the next state so the registered strobes line up with ACCESS cycles.
    always_comb begin
        acc_s      = (state_d == S_ACCESS);
        wr_s       = (we_d != 4'b0000);
        we_pulse_s = (cnt_d != LAST_CNT);
        base_d     = ram_drive(acc_s && !tgt_ext_d, wr_s, we_pulse_s, waddr_d, we_d, wdata_d, base_q.addr);
        ext_d      = ram_drive(acc_s && tgt_ext_d, wr_s, we_pulse_s, waddr_d, we_d, wdata_d, ext_q.addr);
        cap_s      = (state_q == S_ACCESS) && (cnt_q == LAST_CNT) && (we_q == 4'b0000);
        rd_word_s  = tgt_ext_q ? ext_ram_data_i : base_ram_data_i;
    end

    // State, latched request and registered pad outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            last_inst_q  <= 1'b1;
            own_data_q   <= 1'b0;
            tgt_ext_q    <= 1'b0;
            waddr_q      <= {ADDR_W{1'b0}};
            we_q         <= 4'b0000;
            wdata_q      <= 32'd0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            grant_inst_q <= 1'b0;
            grant_data_q <= 1'b0;
            base_q       <= BUS_IDLE;
            ext_q        <= BUS_IDLE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_inst_q  <= last_inst_d;
            own_data_q   <= own_data_d;
            tgt_ext_q    <= tgt_ext_d;
            waddr_q      <= waddr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            inst_ready_q <= (state_d == S_DONE) && !own_data_d;
            data_ready_q <= (state_d == S_DONE) && own_data_d;
            grant_inst_q <= acc_s && !own_data_d;
            grant_data_q <= acc_s && own_data_d;
            base_q       <= base_d;
            ext_q        <= ext_d;
        end
    end

    // Read data is sampled at the edge leaving the last ACCESS cycle; stores leave rdata alone.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else if (cap_s && own_data_q) begin
            data_rdata_q <= rd_word_s;
        end else if (cap_s) begin
            inst_rdata_q <= rd_word_s;
        end
    end

    assign inst_ready_o       = inst_ready_q;
    assign inst_rdata_o       = inst_rdata_q;
    assign data_ready_o       = data_ready_q;
    assign data_rdata_o       = data_rdata_q;
    assign grant_inst_o       = grant_inst_q;
    assign grant_data_o       = grant_data_q;
    assign base_ram_addr_o    = base_q.addr;
    assign base_ram_be_n_o    = base_q.be_n;
    assign base_ram_ce_n_o    = base_q.ce_n;
    assign base_ram_oe_n_o    = base_q.oe_n;
    assign base_ram_we_n_o    = base_q.we_n;
    assign base_ram_data_o    = base_q.data;
    assign base_ram_data_oe_o = base_q.data_oe;
    assign ext_ram_addr_o     = ext_q.addr;
    assign ext_ram_be_n_o     = ext_q.be_n;
    assign ext_ram_ce_n_o     = ext_q.ce_n;
    assign ext_ram_oe_n_o     = ext_q.oe_n;
    assign ext_ram_we_n_o     = ext_q.we_n;
    assign ext_ram_data_o     = ext_q.data;
    assign ext_ram_data_oe_o  = ext_q.data_oe;

endmodule
